// File: rtl/round_pipe_pkg.sv
// Shared FPU rounding types and width-derived constants used by the round_pipe
// datapath and, later, by the adder/divider rounding paths.
package round_pipe_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_t;

    // All-ones biased exponent (infinity / NaN encoding) for a given width.
    function automatic int EXP_MAX(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Significand with only the hidden bit set.
    function automatic int MANT_ONE(input int mant_w);
        return 1 << (mant_w - 1);
    endfunction

endpackage

// File: rtl/round_pipe_if.sv
// Valid/ready streaming bundle for the rounding unit: pre-round input side
// and rounded output side.
interface round_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    import round_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_guard;
    logic              in_sticky;
    round_t            in_rnd;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_inexact;
    logic              out_overflow;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky, in_rnd,
        input  out_ready,
        output in_ready,
        output out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky, in_rnd,
        output out_ready,
        input  in_ready,
        input  out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
    );

endinterface

// File: rtl/round_pipe_decide.sv
// Combinational rounding decision: increment, inexact and whether an overflow
// saturates to max finite instead of infinity for the given mode and sign.
module round_decide
    import round_pipe_pkg::*;
(
    input  round_t rnd,
    input  logic   sign,
    input  logic   g,
    input  logic   s,
    input  logic   lsb,
    output logic   inc,
    output logic   inexact,
    output logic   ovf_to_max
);

    always_comb begin
        inexact    = g | s;
        inc        = 1'b0;
        ovf_to_max = 1'b0;
        case (rnd)
            IEEE_zero: begin
                inc        = 1'b0;
                ovf_to_max = 1'b1;
            end
            IEEE_pinf: begin
                inc        = ~sign & (g | s);
                ovf_to_max = sign;
            end
            IEEE_ninf: begin
                inc        = sign & (g | s);
                ovf_to_max = ~sign;
            end
            near_up:   inc = g & (s | ~sign);
            away_zero: inc = g | s;
            // Unused encodings fall back to round-to-nearest-even.
            default:   inc = g & (s | lsb);
        endcase
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage pipelined rounding unit: stage 1 captures operands and the rounding
// decision, stage 2 holds the incremented, renormalised and overflow-handled result.
module round_pipe
    import round_pipe_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    round_pipe_if.slave       bus,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  inexact_cnt
);

    localparam logic [EXP_W-1:0]  EXP_ONES   = EXP_W'(EXP_MAX(EXP_W));
    localparam logic [EXP_W-1:0]  EXP_MAXFIN = EXP_ONES - EXP_W'(1);
    localparam logic [MANT_W-1:0] MANT_HID   = MANT_W'(MANT_ONE(MANT_W));
    localparam logic [MANT_W-1:0] MANT_ONES  = '1;
    localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic [EXP_W-1:0]  s1_exp_reg;
    logic [MANT_W-1:0] s1_mant_reg;
    logic              s1_inc_reg;
    logic              s1_inexact_reg;
    logic              s1_max_reg;

    logic              s2_valid_reg;
    logic              s2_sign_reg;
    logic [EXP_W-1:0]  s2_exp_reg;
    logic [MANT_W-1:0] s2_mant_reg;
    logic              s2_inexact_reg;
    logic              s2_overflow_reg;

    logic [CNT_W-1:0]  cnt_reg;

    logic s2_adv, s1_adv, in_fire, out_fire;
    logic dec_inc, dec_inexact, dec_max;

    assign s2_adv       = !s2_valid_reg | bus.out_ready;
    assign s1_adv       = !s1_valid_reg | s2_adv;
    assign bus.in_ready = rst_n & s1_adv;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign out_fire     = s2_valid_reg & bus.out_ready;

    round_decide u_decide (
        .rnd        (bus.in_rnd),
        .sign       (bus.in_sign),
        .g          (bus.in_guard),
        .s          (bus.in_sticky),
        .lsb        (bus.in_mant[0]),
        .inc        (dec_inc),
        .inexact    (dec_inexact),
        .ovf_to_max (dec_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_exp_reg     <= '0;
            s1_mant_reg    <= '0;
            s1_inc_reg     <= 1'b0;
            s1_inexact_reg <= 1'b0;
            s1_max_reg     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (in_fire) begin
                s1_sign_reg    <= bus.in_sign;
                s1_exp_reg     <= bus.in_exp;
                s1_mant_reg    <= bus.in_mant;
                s1_inc_reg     <= dec_inc;
                s1_inexact_reg <= dec_inexact;
                s1_max_reg     <= dec_max;
            end
        end
    end

    logic [MANT_W:0]   sum;
    logic              carry;
    logic [EXP_W-1:0]  rnd_exp;
    logic [MANT_W-1:0] rnd_mant;
    logic              ovf;
    logic [EXP_W-1:0]  s2_exp_next;
    logic [MANT_W-1:0] s2_mant_next;
    logic              s2_inexact_next;

    assign sum      = {1'b0, s1_mant_reg} + (MANT_W+1)'(s1_inc_reg);
    assign carry    = sum[MANT_W];
    // A carry out of the significand means it became exactly 2.0: renormalise.
    assign rnd_mant = carry ? MANT_HID : sum[MANT_W-1:0];
    assign rnd_exp  = s1_exp_reg + EXP_W'(carry);
    // Checking the incoming exponent too catches the wrap of all-ones plus carry.
    assign ovf      = (rnd_exp == EXP_ONES) | (s1_exp_reg == EXP_ONES);

    always_comb begin
        s2_exp_next     = rnd_exp;
        s2_mant_next    = rnd_mant;
        s2_inexact_next = s1_inexact_reg | ovf;
        if (ovf) begin
            if (s1_max_reg) begin
                s2_exp_next  = EXP_MAXFIN;
                s2_mant_next = MANT_ONES;
            end else begin
                s2_exp_next  = EXP_ONES;
                s2_mant_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg    <= 1'b0;
            s2_sign_reg     <= 1'b0;
            s2_exp_reg      <= '0;
            s2_mant_reg     <= '0;
            s2_inexact_reg  <= 1'b0;
            s2_overflow_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sign_reg     <= s1_sign_reg;
                s2_exp_reg      <= s2_exp_next;
                s2_mant_reg     <= s2_mant_next;
                s2_inexact_reg  <= s2_inexact_next;
                s2_overflow_reg <= ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear_cnt) begin
            cnt_reg <= '0;
        end else if (out_fire && s2_inexact_reg && (cnt_reg != CNT_SAT)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bus.out_valid    = s2_valid_reg;
    assign bus.out_sign     = s2_sign_reg;
    assign bus.out_exp      = s2_exp_reg;
    assign bus.out_mant     = s2_mant_reg;
    assign bus.out_inexact  = s2_inexact_reg;
    assign bus.out_overflow = s2_overflow_reg;
    assign inexact_cnt      = cnt_reg;

endmodule

// File: tb/tb_round_pipe.sv
// Scoreboard bench for round_pipe: directed vectors push expected results, an
// independent monitor pops and compares on every output transfer.
module tb_round_pipe;
    import round_pipe_pkg::*;

    localparam int MW = 24;
    localparam int EW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_cnt = 1'b0;
    logic [CW-1:0] inexact_cnt;

    round_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    round_pipe #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .clear_cnt   (clear_cnt),
        .inexact_cnt (inexact_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
        logic          g;
        logic          s;
        logic [2:0]    rnd;
        logic [EW-1:0] e_exp;
        logic [MW-1:0] e_mant;
        logic          e_inx;
        logic          e_ovf;
    } vec_t;

    typedef struct {
        logic [34:0] data;
        int          in_cyc;
        bit          chk_lat;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_out = 0;
    logic        hold_valid = 1'b0;
    logic [34:0] held;
    logic [34:0] act;

    function automatic vec_t mk(logic sg, logic [7:0] e, logic [23:0] m, logic g, logic s,
                                logic [2:0] r, logic [7:0] ee, logic [23:0] em, logic ei, logic eo);
        vec_t v;
        v.sign = sg; v.exp = e; v.mant = m; v.g = g; v.s = s; v.rnd = r;
        v.e_exp = ee; v.e_mant = em; v.e_inx = ei; v.e_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: compare on transfer, and check data is held while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            act = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow};
            if (hold_valid) check("hold", 64'(act), 64'(held));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h required no output", act);
                end else begin
                    cur = sb.pop_front();
                    $display("[TB] out %0d: sign=%b exp=%h mant=%h inx=%b ovf=%b", n_out,
                             bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow);
                    check("data", 64'(act), 64'(cur.data));
                    if (cur.chk_lat) check("latency", 64'(cyc - cur.in_cyc), 64'd2);
                end
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            held = act;
        end
    end

    // Occupancy model: in_ready may only drop when both stages hold an item.
    always @(posedge clk) begin
        #2;
        if (rst_n) check("in_ready", 64'(bus.in_ready), 64'((sb.size() < 2) || bus.out_ready));
    end

    task automatic send(input int idx, input bit chk_lat);
        vec_t v;
        bit   done;
        v = vecs[idx];
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sign   = v.sign;
        bus.in_exp    = v.exp;
        bus.in_mant   = v.mant;
        bus.in_guard  = v.g;
        bus.in_sticky = v.s;
        bus.in_rnd    = round_t'(v.rnd);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{data: {v.sign, v.e_exp, v.e_mant, v.e_inx, v.e_ovf},
                               in_cyc: cyc, chk_lat: chk_lat});
                $display("[TB] in vec %0d: sign=%b exp=%h mant=%h g=%b s=%b rnd=%0d",
                         idx, v.sign, v.exp, v.mant, v.g, v.s, v.rnd);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1");
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        for (int t = 0; t < maxc && sb.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n0;
        vecs[0]  = mk(0, 8'h80, 24'h800000, 1, 0, 3'd0, 8'h80, 24'h800000, 1, 0);
        vecs[1]  = mk(0, 8'h80, 24'h800001, 1, 0, 3'd0, 8'h80, 24'h800002, 1, 0);
        vecs[2]  = mk(0, 8'h80, 24'h800000, 0, 0, 3'd0, 8'h80, 24'h800000, 0, 0);
        vecs[3]  = mk(0, 8'h80, 24'hFFFFFF, 1, 1, 3'd5, 8'h81, 24'h800000, 1, 0);
        vecs[4]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 3'd0, 8'hFF, 24'h000000, 1, 1);
        vecs[5]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 3'd1, 8'hFE, 24'hFFFFFF, 1, 0);
        vecs[6]  = mk(1, 8'h80, 24'h800000, 0, 1, 3'd2, 8'h80, 24'h800000, 1, 0);
        vecs[7]  = mk(1, 8'h80, 24'h800000, 0, 1, 3'd3, 8'h80, 24'h800001, 1, 0);
        vecs[8]  = mk(1, 8'h80, 24'h800000, 0, 1, 3'd5, 8'h80, 24'h800001, 1, 0);
        vecs[9]  = mk(1, 8'h80, 24'h800000, 1, 0, 3'd4, 8'h80, 24'h800000, 1, 0);
        vecs[10] = mk(0, 8'h80, 24'h800000, 1, 0, 3'd4, 8'h80, 24'h800001, 1, 0);
        vecs[11] = mk(0, 8'hFF, 24'hFFFFFF, 0, 0, 3'd1, 8'hFE, 24'hFFFFFF, 1, 1);
        vecs[12] = mk(1, 8'hFF, 24'h800000, 0, 0, 3'd2, 8'hFE, 24'hFFFFFF, 1, 1);
        vecs[13] = mk(0, 8'hFF, 24'h800000, 0, 0, 3'd0, 8'hFF, 24'h000000, 1, 1);
        vecs[14] = mk(0, 8'h80, 24'h800001, 1, 0, 3'd7, 8'h80, 24'h800002, 1, 0);
        vecs[15] = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 3'd3, 8'hFE, 24'hFFFFFF, 1, 0);
        vecs[16] = mk(0, 8'hFE, 24'hFFFFFF, 0, 1, 3'd2, 8'hFF, 24'h000000, 1, 1);

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_guard  = 1'b0;
        bus.in_sticky = 1'b0;
        bus.in_rnd    = IEEE_near;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'({bus.out_sign, bus.out_exp, bus.out_mant,
                                   bus.out_inexact, bus.out_overflow}), 64'd0);
        check("rst_cnt", 64'(inexact_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single directed vectors, unstalled, with latency check
        for (int i = 0; i < 17; i++) begin
            send(i, 1'b1);
            idle();
            drain(20);
        end

        // Back-to-back burst with downstream stall in cycles 3..5
        n0 = n_out;
        fork
            begin
                for (int i = 3; i < 9; i++) send(i, 1'b0);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain(50);
        check("burst_count", 64'(n_out - n0), 64'd6);

        // Saturating inexact counter
        clear_cnt = 1'b1;
        @(posedge clk);
        #1 clear_cnt = 1'b0;
        @(negedge clk);
        check("cnt_cleared", 64'(inexact_cnt), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send(0, 1'b0);
        idle();
        drain(50);
        @(negedge clk);
        check("cnt_10", 64'(inexact_cnt), 64'd10);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send(1, 1'b0);
        idle();
        drain(50);
        @(negedge clk);
        check("cnt_sat", 64'(inexact_cnt), 64'd15);
        @(posedge clk);
        #1 clear_cnt = 1'b1;
        @(posedge clk);
        #1 clear_cnt = 1'b0;
        @(negedge clk);
        check("cnt_clear_after_sat", 64'(inexact_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Reset with two items in flight
        bus.out_ready = 1'b0;
        send(3, 1'b0);
        send(4, 1'b0);
        idle();
        @(negedge clk);
        check("inflight_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_out", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(10, 1'b1);
        idle();
        drain(20);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

endmodule
